// File: rtl/id_reg_sb_if.sv
// id_reg_sb_if: one decoded-instruction bundle.
// Instantiated twice around id_reg_sb: once carrying the decoder outputs into
// the register, and once carrying the registered ID/EX copies out to EX.
//   en          instruction valid
//   pc          word address of the instruction
//   alu_op      ALU operation
//   alu_in_0/1  ALU operands
//   br_flag     branch taken flag
//   mem_op      memory operation (NOP/LDW/STW)
//   mem_wr_data store data
//   ctrl_op     control operation
//   dst_addr    destination GPR
//   gpr_we_     GPR write enable, active low
//   exp_code    exception code
// Modports: master drives the bundle, slave reads it.
interface id_reg_sb_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 30,
  parameter int REG_AW = 5
);
  logic              en;
  logic [PC_W-1:0]   pc;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_in_0;
  logic [DATA_W-1:0] alu_in_1;
  logic              br_flag;
  logic [1:0]        mem_op;
  logic [DATA_W-1:0] mem_wr_data;
  logic [1:0]        ctrl_op;
  logic [REG_AW-1:0] dst_addr;
  logic              gpr_we_;
  logic [2:0]        exp_code;

  modport master (
    output en, pc, alu_op, alu_in_0, alu_in_1, br_flag, mem_op,
           mem_wr_data, ctrl_op, dst_addr, gpr_we_, exp_code
  );

  modport slave (
    input en, pc, alu_op, alu_in_0, alu_in_1, br_flag, mem_op,
          mem_wr_data, ctrl_op, dst_addr, gpr_we_, exp_code
  );
endinterface

// File: rtl/id_reg_sb.sv
// id_reg_sb: ID/EX pipeline register with a load-use scoreboard.
// Latches the decoded instruction every un-stalled cycle and tracks up to
// LD_LAT in-flight LDW destinations so that a dependent instruction in decode
// is held (ld_hazard) until the load result can be forwarded.
// Ports:
//   clk        rising-edge clock
//   reset_     asynchronous active-low reset
//   stall      freeze register and scoreboard
//   flush      kill ID/EX contents and scoreboard (wins over stall)
//   ra_addr    source register A of the instruction in decode
//   rb_addr    source register B of the instruction in decode
//   dec        decoder outputs (slave side of id_reg_sb_if)
//   id         registered ID/EX copies (master side of id_reg_sb_if)
//   ld_hazard  combinational load-use hazard, IF/ID holds while high
// Optional build macro: LDH_R0_FILTER_EN -- when defined, scoreboard entries
// targeting register 0 never raise ld_hazard (r0 is never forwarded).
module id_reg_sb #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 30,
  parameter int REG_AW = 5,
  parameter int LD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  id_reg_sb_if.slave        dec,
  id_reg_sb_if.master       id,
  output logic              ld_hazard
);

  localparam logic [3:0] ALU_OP_NOP     = 4'h0;
  localparam logic [1:0] MEM_OP_NOP     = 2'h0;
  localparam logic [1:0] MEM_OP_LDW     = 2'h1;
  localparam logic [1:0] CTRL_OP_NOP    = 2'h0;
  localparam logic [2:0] ISA_EXP_NO_EXP = 3'h0;
  localparam logic       DISABLE_       = 1'b1;
  localparam logic       ENABLE_        = 1'b0;

`ifdef LDH_R0_FILTER_EN
  localparam logic R0_FILTER = 1'b1;
`else
  localparam logic R0_FILTER = 1'b0;
`endif

  logic              en_q;
  logic [PC_W-1:0]   pc_q;
  logic [3:0]        alu_op_q;
  logic [DATA_W-1:0] alu_in_0_q;
  logic [DATA_W-1:0] alu_in_1_q;
  logic              br_flag_q;
  logic [1:0]        mem_op_q;
  logic [DATA_W-1:0] mem_wr_data_q;
  logic [1:0]        ctrl_op_q;
  logic [REG_AW-1:0] dst_addr_q;
  logic              gpr_we_q;
  logic [2:0]        exp_code_q;

  logic [LD_LAT-1:0] sb_vld;
  logic [REG_AW-1:0] sb_dst [LD_LAT];

  logic load;
  logic ld_issue;

  // A held-back instruction becomes a bubble; only real loads occupy a slot.
  assign load     = dec.en && !ld_hazard;
  assign ld_issue = load && (dec.mem_op == MEM_OP_LDW) && (dec.gpr_we_ == ENABLE_);

  always_comb begin
    ld_hazard = 1'b0;
    for (int k = 0; k < LD_LAT; k++) begin
      if (sb_vld[k] && ((sb_dst[k] == ra_addr) || (sb_dst[k] == rb_addr)) &&
          !(R0_FILTER && (sb_dst[k] == '0))) begin
        ld_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sb_vld <= '0;
      for (int k = 0; k < LD_LAT; k++) sb_dst[k] <= '0;
    end else if (flush) begin
      sb_vld <= '0;
    end else if (!stall) begin
      // Entry LD_LAT-1 falls off the end and retires.
      for (int k = LD_LAT - 1; k > 0; k--) begin
        sb_vld[k] <= sb_vld[k-1];
        sb_dst[k] <= sb_dst[k-1];
      end
      sb_vld[0] <= ld_issue;
      sb_dst[0] <= dec.dst_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      en_q          <= 1'b0;
      pc_q          <= '0;
      alu_op_q      <= ALU_OP_NOP;
      alu_in_0_q    <= '0;
      alu_in_1_q    <= '0;
      br_flag_q     <= 1'b0;
      mem_op_q      <= MEM_OP_NOP;
      mem_wr_data_q <= '0;
      ctrl_op_q     <= CTRL_OP_NOP;
      dst_addr_q    <= '0;
      gpr_we_q      <= DISABLE_;
      exp_code_q    <= ISA_EXP_NO_EXP;
    end else if (flush) begin
      en_q          <= 1'b0;
      pc_q          <= '0;
      alu_op_q      <= ALU_OP_NOP;
      alu_in_0_q    <= '0;
      alu_in_1_q    <= '0;
      br_flag_q     <= 1'b0;
      mem_op_q      <= MEM_OP_NOP;
      mem_wr_data_q <= '0;
      ctrl_op_q     <= CTRL_OP_NOP;
      dst_addr_q    <= '0;
      gpr_we_q      <= DISABLE_;
      exp_code_q    <= ISA_EXP_NO_EXP;
    end else if (!stall) begin
      if (load) begin
        en_q          <= 1'b1;
        pc_q          <= dec.pc;
        alu_op_q      <= dec.alu_op;
        alu_in_0_q    <= dec.alu_in_0;
        alu_in_1_q    <= dec.alu_in_1;
        br_flag_q     <= dec.br_flag;
        mem_op_q      <= dec.mem_op;
        mem_wr_data_q <= dec.mem_wr_data;
        ctrl_op_q     <= dec.ctrl_op;
        dst_addr_q    <= dec.dst_addr;
        gpr_we_q      <= dec.gpr_we_;
        exp_code_q    <= dec.exp_code;
      end else begin
        // Bubble: kill every side effect, data fields keep stale values.
        en_q       <= 1'b0;
        br_flag_q  <= 1'b0;
        mem_op_q   <= MEM_OP_NOP;
        ctrl_op_q  <= CTRL_OP_NOP;
        gpr_we_q   <= DISABLE_;
        exp_code_q <= ISA_EXP_NO_EXP;
      end
    end
  end

  assign id.en          = en_q;
  assign id.pc          = pc_q;
  assign id.alu_op      = alu_op_q;
  assign id.alu_in_0    = alu_in_0_q;
  assign id.alu_in_1    = alu_in_1_q;
  assign id.br_flag     = br_flag_q;
  assign id.mem_op      = mem_op_q;
  assign id.mem_wr_data = mem_wr_data_q;
  assign id.ctrl_op     = ctrl_op_q;
  assign id.dst_addr    = dst_addr_q;
  assign id.gpr_we_     = gpr_we_q;
  assign id.exp_code    = exp_code_q;

endmodule
